// File: rtl/tag_pkg.sv
// Shared types and sizes for the 16-port tag crossbar.
// The tag payload is opaque to the crossbar; the struct documents its layout.
`ifndef ADDR_LENTH
`define ADDR_LENTH 16
`endif

package tag_pkg;

    localparam int NPORT     = 16;
    localparam int PORT_W    = 4;
    localparam int PRI_W     = 3;
    localparam int MSG_W     = `ADDR_LENTH + 4;
    localparam int TAG_WIDTH = `ADDR_LENTH + 11;

    typedef struct packed {
        logic [PRI_W-1:0]  pri;
        logic [MSG_W-1:0]  msg;
        logic [PORT_W-1:0] srcPort;
    } tag_t;

    function automatic tag_t mkTag(
        input logic [PRI_W-1:0]  pri,
        input logic [MSG_W-1:0]  msg,
        input logic [PORT_W-1:0] srcPort
    );
        tag_t t;
        t.pri     = pri;
        t.msg     = msg;
        t.srcPort = srcPort;
        return t;
    endfunction

endpackage

// File: rtl/dcp_decoupled_if.sv
// Decoupled valid/ready channel carrying a tag payload and a port field.
// Dst means destination on the sink side and source index on the source side.
interface dcp_decoupled_if
    import tag_pkg::*;
#(
    parameter int DW = TAG_WIDTH,
    parameter int AW = PORT_W
);

    logic          Vld;
    logic          Rdy;
    logic [AW-1:0] Dst;
    logic [DW-1:0] Pld;

    modport sink (
        input  Vld,
        input  Dst,
        input  Pld,
        output Rdy
    );

    modport source (
        output Vld,
        output Dst,
        output Pld,
        input  Rdy
    );

endinterface

// File: rtl/rr_arb16.sv
// 16-way round-robin arbiter, purely combinational.
// Grants the first requester at or above ptr, wrapping from 15 to 0.
module rr_arb16
    import tag_pkg::*;
(
    input  logic [NPORT-1:0]  req,
    input  logic [PORT_W-1:0] ptr,
    output logic [NPORT-1:0]  gnt,
    output logic [PORT_W-1:0] idx,
    output logic              any
);

    logic [PORT_W-1:0] cand;

    // Rotating priority scan starting at the pointer
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < NPORT; k++) begin
            cand = ptr + PORT_W'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dcp_tag_xbar16x16.sv
// 16x16 tag crossbar: per-output round-robin arbitration, one register stage.
// Input Rdy depends only on Vld/Dst and output state, never on payload.
module dcp_tag_xbar16x16
    import tag_pkg::*;
(
    input  logic            iClk,
    input  logic            iRst,
    dcp_decoupled_if.sink   iTagIn  [NPORT],
    dcp_decoupled_if.source oTagOut [NPORT]
);

    localparam int DW = TAG_WIDTH;
    localparam int AW = PORT_W;

    logic [NPORT-1:0] inVld;
    logic [AW-1:0]    inDst [NPORT];
    logic [DW-1:0]    inPld [NPORT];
    logic [NPORT-1:0] inRdy;
    logic [NPORT-1:0] outRdy;

    logic [NPORT-1:0] canAcc;
    logic [NPORT-1:0] req   [NPORT];
    logic [NPORT-1:0] gnt   [NPORT];
    logic [AW-1:0]    gIdx  [NPORT];
    logic [NPORT-1:0] gAny;

    logic [NPORT-1:0] regVld;
    logic [DW-1:0]    regPld [NPORT];
    logic [AW-1:0]    regSrc [NPORT];
    logic [AW-1:0]    rrPtr  [NPORT];

    for (genvar g = 0; g < NPORT; g++) begin : gPort
        assign inVld[g]        = iTagIn[g].Vld;
        assign inDst[g]        = iTagIn[g].Dst;
        assign inPld[g]        = iTagIn[g].Pld;
        assign iTagIn[g].Rdy   = inRdy[g];

        assign oTagOut[g].Vld  = regVld[g];
        assign oTagOut[g].Dst  = regSrc[g];
        assign oTagOut[g].Pld  = regPld[g];
        assign outRdy[g]       = oTagOut[g].Rdy;

        rr_arb16 uArb (
            .req (req[g]),
            .ptr (rrPtr[g]),
            .gnt (gnt[g]),
            .idx (gIdx[g]),
            .any (gAny[g])
        );
    end

    // An output accepts when empty or when its current tag is consumed
    always_comb begin
        canAcc = ~regVld | outRdy;
    end

    // Transpose per-input destination into per-output request columns
    always_comb begin
        for (int d = 0; d < NPORT; d++) begin
            req[d] = '0;
            for (int i = 0; i < NPORT; i++) begin
                req[d][i] = inVld[i]
                          && (inDst[i] == AW'(d))
                          && canAcc[d]
                          && !iRst;
            end
        end
    end

    // Input ready is the OR of its grant across all outputs
    always_comb begin
        inRdy = '0;
        for (int d = 0; d < NPORT; d++) begin
            inRdy = inRdy | gnt[d];
        end
    end

    // Output registers and round-robin pointers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            regVld <= '0;
            for (int d = 0; d < NPORT; d++) begin
                regPld[d] <= '0;
                regSrc[d] <= '0;
                rrPtr[d]  <= '0;
            end
        end else begin
            for (int d = 0; d < NPORT; d++) begin
                if (gAny[d]) begin
                    regVld[d] <= 1'b1;
                    regPld[d] <= inPld[gIdx[d]];
                    regSrc[d] <= gIdx[d];
                    rrPtr[d]  <= gIdx[d] + AW'(1);
                end else if (outRdy[d]) begin
                    regVld[d] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcp_tag_xbar16x16.sv
// Bench for the 16x16 tag crossbar: directed tables plus random traffic
// checked against a per-output round-robin model.
module tb_dcp_tag_xbar16x16;
    import tag_pkg::*;

    logic clk = 1'b0;
    logic tRst;
    always #5 clk = ~clk;

    dcp_decoupled_if inIf  [NPORT] ();
    dcp_decoupled_if outIf [NPORT] ();

    logic [NPORT-1:0]     tVld;
    logic [PORT_W-1:0]    tDst [NPORT];
    logic [TAG_WIDTH-1:0] tPld [NPORT];
    logic [NPORT-1:0]     tRdy;
    logic [NPORT-1:0]     oRdy;
    logic [NPORT-1:0]     oVldV;
    logic [PORT_W-1:0]    oDstA [NPORT];
    logic [TAG_WIDTH-1:0] oPldA [NPORT];

    for (genvar g = 0; g < NPORT; g++) begin : gMap
        assign inIf[g].Vld  = tVld[g];
        assign inIf[g].Dst  = tDst[g];
        assign inIf[g].Pld  = tPld[g];
        assign tRdy[g]      = inIf[g].Rdy;
        assign oVldV[g]     = outIf[g].Vld;
        assign oDstA[g]     = outIf[g].Dst;
        assign oPldA[g]     = outIf[g].Pld;
        assign outIf[g].Rdy = oRdy[g];
    end

    dcp_tag_xbar16x16 dut (
        .iClk    (clk),
        .iRst    (tRst),
        .iTagIn  (inIf),
        .oTagOut (outIf)
    );

    int nVec  = 0;
    int nFail = 0;

    bit                   mVld [NPORT];
    logic [TAG_WIDTH-1:0] mPld [NPORT];
    int                   mSrc [NPORT];
    int                   mPtr [NPORT];
    logic [NPORT-1:0]     lastRdy;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
        end
    endtask

    // One clock: predict grants, check Rdy, clock, check outputs.
    task automatic cycle();
        logic [NPORT-1:0] er;
        int gr [NPORT];
        er = '0;
        for (int d = 0; d < NPORT; d++) begin
            gr[d] = -1;
            if (!tRst && (!mVld[d] || oRdy[d])) begin
                for (int k = 0; k < NPORT; k++) begin
                    int i;
                    i = (mPtr[d] + k) % NPORT;
                    if (gr[d] < 0 && tVld[i] && tDst[i] == PORT_W'(d))
                        gr[d] = i;
                end
            end
            if (gr[d] >= 0) er[gr[d]] = 1'b1;
        end
        #1;
        lastRdy = tRdy;
        chk("inRdy", 64'(tRdy), 64'(er));
        @(posedge clk);
        for (int d = 0; d < NPORT; d++) begin
            if (tRst) begin
                mVld[d] = 1'b0;
                mPtr[d] = 0;
            end else if (gr[d] >= 0) begin
                mVld[d] = 1'b1;
                mPld[d] = tPld[gr[d]];
                mSrc[d] = gr[d];
                mPtr[d] = (gr[d] + 1) % NPORT;
            end else if (oRdy[d]) begin
                mVld[d] = 1'b0;
            end
        end
        #1;
        for (int d = 0; d < NPORT; d++) begin
            chk("outVld", 64'(oVldV[d]), 64'(mVld[d]));
            if (mVld[d])
                chk("outDstPld", {33'(oDstA[d]), 31'(oPldA[d])},
                    {33'(mSrc[d]), 31'(mPld[d])});
        end
    endtask

    task automatic idleAll();
        tVld = '0;
        for (int i = 0; i < NPORT; i++) begin
            tDst[i] = '0;
            tPld[i] = '0;
        end
    endtask

    task automatic doReset();
        tRst = 1'b1;
        cycle();
        tRst = 1'b0;
    endtask

    typedef struct {
        logic [PORT_W-1:0] dst;
        tag_t              pld;
        logic [NPORT-1:0]  expMask;
    } ssVec_t;

    ssVec_t ss [NPORT];

    initial begin
        for (int k = 0; k < NPORT; k++) begin
            ss[k].dst     = PORT_W'(k);
            ss[k].pld     = mkTag(PRI_W'(k % 8), MSG_W'(k), 4'd0);
            ss[k].expMask = NPORT'(1) << k;
        end
        for (int d = 0; d < NPORT; d++) begin
            mVld[d] = 1'b0;
            mPld[d] = '0;
            mSrc[d] = 0;
            mPtr[d] = 0;
        end
        tRst = 1'b1;
        oRdy = '1;
        idleAll();
        tVld[0] = 1'b1;
        cycle();
        chk("rstRdy", 64'(lastRdy), 64'd0);
        chk("rstVld", 64'(oVldV), 64'd0);
        tRst = 1'b0;
        idleAll();
        cycle();

        // Single source sweeping all destinations
        for (int k = 0; k < NPORT; k++) begin
            idleAll();
            tVld[0] = 1'b1;
            tDst[0] = ss[k].dst;
            tPld[0] = ss[k].pld;
            cycle();
            chk("ssRdy", 64'(lastRdy[0]), 64'd1);
            chk("ssMask", 64'(oVldV), 64'(ss[k].expMask));
            chk("ssDst", 64'(oDstA[k]), 64'd0);
            chk("ssPld", 64'(oPldA[k]), 64'(ss[k].pld));
        end
        idleAll();
        cycle();
        chk("ssDrain", 64'(oVldV), 64'd0);

        // Full contention on output 5
        doReset();
        for (int i = 0; i < NPORT; i++) begin
            tVld[i] = 1'b1;
            tDst[i] = 4'd5;
            tPld[i] = TAG_WIDTH'(i);
        end
        for (int c = 0; c < NPORT; c++) begin
            cycle();
            chk("fcRdy", 64'(lastRdy), 64'(NPORT'(1) << c));
            chk("fcMask", 64'(oVldV), 64'h20);
            chk("fcDst", 64'(oDstA[5]), 64'(c));
            tVld = tVld & ~lastRdy;
        end
        idleAll();
        cycle();

        // Permutation: every input to a distinct output
        for (int i = 0; i < NPORT; i++) begin
            tVld[i] = 1'b1;
            tDst[i] = PORT_W'(15 - i);
            tPld[i] = TAG_WIDTH'($urandom);
        end
        cycle();
        chk("permRdy", 64'(lastRdy), 64'hFFFF);
        chk("permVld", 64'(oVldV), 64'hFFFF);
        for (int d = 0; d < NPORT; d++)
            chk("permDst", 64'(oDstA[d]), 64'(15 - d));
        idleAll();
        cycle();

        // Backpressure on output 3
        oRdy[3] = 1'b0;
        tVld[2] = 1'b1;
        tDst[2] = 4'd3;
        tPld[2] = TAG_WIDTH'(32'h0a2);
        cycle();
        chk("bpRdy2", 64'(lastRdy[2]), 64'd1);
        idleAll();
        tVld[7] = 1'b1;
        tDst[7] = 4'd3;
        tPld[7] = TAG_WIDTH'(32'h0a7);
        for (int c = 0; c < 2; c++) begin
            cycle();
            chk("bpHoldRdy7", 64'(lastRdy[7]), 64'd0);
            chk("bpHoldDst", 64'(oDstA[3]), 64'd2);
            chk("bpHoldPld", 64'(oPldA[3]), 64'h0a2);
        end
        oRdy[3] = 1'b1;
        cycle();
        chk("bpRdy7", 64'(lastRdy[7]), 64'd1);
        chk("bpDst7", 64'(oDstA[3]), 64'd7);
        idleAll();
        cycle();
        chk("bpEmpty", 64'(oVldV[3]), 64'd0);

        // Round-robin pointer after input 6 served on output 0
        tVld[6] = 1'b1;
        tDst[6] = 4'd0;
        cycle();
        idleAll();
        tVld[4] = 1'b1;
        tVld[9] = 1'b1;
        cycle();
        chk("rrFirst", 64'(lastRdy), 64'(16'h0200));
        tVld[9] = 1'b0;
        cycle();
        chk("rrSecond", 64'(lastRdy), 64'(16'h0010));
        idleAll();
        cycle();

        // Reset in the middle of traffic
        for (int i = 0; i < NPORT; i++) begin
            tVld[i] = 1'b1;
            tDst[i] = PORT_W'(i);
            tPld[i] = TAG_WIDTH'($urandom);
        end
        cycle();
        chk("preRstVld", 64'(oVldV), 64'hFFFF);
        tRst = 1'b1;
        cycle();
        chk("midRstRdy", 64'(lastRdy), 64'd0);
        chk("midRstVld", 64'(oVldV), 64'd0);
        tRst = 1'b0;
        idleAll();
        tVld[0]  = 1'b1;
        tVld[3]  = 1'b1;
        tVld[15] = 1'b1;
        tDst[0]  = 4'd2;
        tDst[3]  = 4'd2;
        tDst[15] = 4'd2;
        cycle();
        chk("postRstRr", 64'(lastRdy), 64'd1);
        idleAll();
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NPORT; i++) begin
                tVld[i] = ($urandom_range(0, 2) != 0);
                tDst[i] = PORT_W'($urandom_range(0, 5));
                tPld[i] = TAG_WIDTH'($urandom);
            end
            oRdy = NPORT'($urandom | $urandom);
            tRst = ($urandom_range(0, 149) == 0);
            cycle();
        end
        tRst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
